// File: rtl/uart_rx_controller_if.sv
// rtl/uart_rx_controller_if.sv - receiver-side, host read-port and status signals of uart_rx_controller
interface uart_rx_controller_if #(
  parameter int DATA_SIZE  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          enable;
  logic [DATA_SIZE-1:0]          rx_data;
  logic                          rx_done;
  logic                          parity_error;
  logic                          stop_error;
  logic                          break_error;
  logic                          rx_start_n;
  logic                          rd_valid;
  logic                          rd_ready;
  logic [DATA_SIZE-1:0]          rd_data;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [3:0]                    err_status;
  logic                          err_clear;
  logic                          timeout_irq;

  modport slave (
    input  enable, rx_data, rx_done, parity_error, stop_error, break_error,
    input  rd_ready, err_clear,
    output rx_start_n, rd_valid, rd_data, fifo_count, err_status, timeout_irq
  );

  modport master (
    output enable, rx_data, rx_done, parity_error, stop_error, break_error,
    output rd_ready, err_clear,
    input  rx_start_n, rd_valid, rd_data, fifo_count, err_status, timeout_irq
  );
endinterface

// File: rtl/uart_rx_controller.sv
// rtl/uart_rx_controller.sv - arms the UART receiver and buffers bytes in a show-ahead FIFO
// Optional idle timeout interrupt built when RX_TIMEOUT_EN is defined.
module uart_rx_controller #(
  parameter int DATA_SIZE      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 640
) (
  input  logic                  clk,
  input  logic                  reset_n,
  uart_rx_controller_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_DISABLED  = 2'd0,
    S_ARMED     = 2'd1,
    S_FULL_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_rx_start_n;
  logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [DATA_SIZE-1:0] r_rd_data;
  logic [3:0]           r_err_status;
  logic                 r_err_pend;
  logic                 r_timeout_irq;

  logic                 w_full;
  logic                 w_rd_valid;
  logic                 w_pop;
  logic                 w_err_evt;
  logic                 w_push_req;
  logic                 w_push;
  logic                 w_overrun;
  logic [AW-1:0]        w_next_rd_ptr;

  assign w_full        = (r_count == DEPTH_C);
  assign w_rd_valid    = (r_count != '0);
  assign w_pop         = w_rd_valid & bus.rd_ready;
  assign w_err_evt     = bus.parity_error | bus.stop_error | bus.break_error;
  assign w_push_req    = bus.rx_done & ~r_err_pend;
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign w_push        = w_push_req & (~w_full | w_pop);
  assign w_overrun     = w_push_req & ~w_push;
  assign w_next_rd_ptr = r_rd_ptr + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_DISABLED;
      r_rx_start_n <= 1'b1;
    end else begin
      case (r_state)
        S_DISABLED: begin
          if (bus.enable && !w_full) begin
            r_state      <= S_ARMED;
            r_rx_start_n <= 1'b0;
          end else if (bus.enable && w_full) begin
            r_state      <= S_FULL_HOLD;
            r_rx_start_n <= 1'b1;
          end
        end
        S_ARMED: begin
          if (!bus.enable) begin
            r_state      <= S_DISABLED;
            r_rx_start_n <= 1'b1;
          end else if (w_full) begin
            r_state      <= S_FULL_HOLD;
            r_rx_start_n <= 1'b1;
          end
        end
        S_FULL_HOLD: begin
          if (!bus.enable) begin
            r_state      <= S_DISABLED;
            r_rx_start_n <= 1'b1;
          end else if (!w_full) begin
            r_state      <= S_ARMED;
            r_rx_start_n <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_DISABLED;
          r_rx_start_n <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_next_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Head register: refilled from memory, or straight from rx_data when the
      // incoming byte becomes the new head; otherwise it holds its last value.
      if (w_pop) begin
        if (w_push && r_count == CW'(1)) begin
          r_rd_data <= bus.rx_data;
        end else if (r_count > CW'(1)) begin
          r_rd_data <= r_mem[w_next_rd_ptr];
        end
      end else if (w_push && r_count == '0) begin
        r_rd_data <= bus.rx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_pend   <= 1'b0;
      r_err_status <= '0;
    end else begin
      if (w_err_evt) begin
        r_err_pend <= 1'b1;
      end else if (bus.rx_done) begin
        r_err_pend <= 1'b0;
      end
      r_err_status <= (bus.err_clear ? 4'b0000 : r_err_status) |
                      {w_overrun, bus.break_error, bus.stop_error, bus.parity_error};
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_idle_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt    <= '0;
      r_timeout_irq <= 1'b0;
    end else if (r_count == '0 || w_push || w_pop) begin
      r_idle_cnt    <= '0;
      r_timeout_irq <= 1'b0;
    end else if (r_idle_cnt != TIMEOUT_C) begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
      if (r_idle_cnt + 16'd1 == TIMEOUT_C) begin
        r_timeout_irq <= 1'b1;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign r_timeout_irq    = 1'b0;
`endif

  assign bus.rx_start_n  = r_rx_start_n;
  assign bus.rd_valid    = w_rd_valid;
  assign bus.rd_data     = r_rd_data;
  assign bus.fifo_count  = r_count;
  assign bus.err_status  = r_err_status;
  assign bus.timeout_irq = r_timeout_irq;
endmodule
